// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the unified-memory arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package mem_arb_pkg;

    // Sequencer states: wait for a request, hold the access, return the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Owner encoding as seen on the owner output.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Default number of ACCESS cycles allowed before an access is aborted.
    localparam int TIMEOUT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module   : mem_arbiter_if
// Brief    : Core, DMA and memory-side signal bundle for mem_arbiter.
//            master = arbiter view, slave = environment (core/DMA/memory) view.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Core port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;

    // DMA / loader port
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_done;

    // Memory macro side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Status
    logic          bus_err;
    logic          owner;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output bus_err, owner
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  bus_err, owner
    );

endinterface

`default_nettype wire

// File: rtl/arb_timer.sv
//==============================================================================
// Module   : arb_timer
// Brief    : 8-bit saturating up-counter with clear/load and a terminal-count
//            flag. tc is high in the cycle whose increment brings the count
//            to TIMEOUT, so TIMEOUT incrementing cycles elapse before abort.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic       clr,
    input  wire logic       load,
    input  wire logic [7:0] load_val,
    input  wire logic       inc,
    output logic            tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear beats load beats increment; saturate at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = inc && (count_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (core / DMA) arbiter and access sequencer for the
//            unified memory. Latches the winning request, holds it on the
//            memory bus until mem_ready or timeout, then pulses done.
//            Optional: define MEMARB_ROUND_ROBIN_EN for alternating tie
//            service; otherwise the core wins every tie.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    mem_arbiter_if.master bus
);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          timer_clr;
    logic          timer_inc;
    logic          timer_tc;
    logic          grant_dma;

    // Winner selection, only consumed in IDLE when at least one port requests.
    always_comb begin
`ifdef MEMARB_ROUND_ROBIN_EN
        if (bus.cpu_req && bus.dma_req) begin
            grant_dma = (owner_q == OWN_CPU);
        end else begin
            grant_dma = bus.dma_req;
        end
`else
        grant_dma = !bus.cpu_req;
`endif
    end

    // Sequencer next-state: latch the winner, wait for ready/timeout, respond.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    owner_d   = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d      = grant_dma ? bus.dma_we    : bus.cpu_we;
                    addr_d    = grant_dma ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d   = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                    timer_clr = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                timer_inc = 1'b1;
                // Ready wins over a coincident timeout.
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_tc) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and access latches; owner resets to DMA so the core wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_DMA;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (timer_clr),
        .load     (1'b0),
        .load_val (8'd0),
        .inc      (timer_inc),
        .tc       (timer_tc)
    );

    // Outputs are decoded from state and latches only; nothing flows through
    // combinationally from the request or mem_ready inputs.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_done  = (state_q == RESP) && (owner_q == OWN_CPU);
    assign bus.dma_done  = (state_q == RESP) && (owner_q == OWN_DMA);
    assign bus.cpu_rdata = bus.cpu_done ? rdata_q : '0;
    assign bus.dma_rdata = bus.dma_done ? rdata_q : '0;
    assign bus.bus_err   = (state_q == RESP) && err_q;
    assign bus.owner     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter. Build with
//            MEMARB_ROUND_ROBIN_EN defined to exercise alternating ties.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_owner;   // model: port served most recently

    typedef struct {
        int          done_at;
        int          en_cnt;
        logic        first_en;
        logic        c_done;
        logic        d_done;
        logic [31:0] c_rd;
        logic [31:0] d_rd;
        logic        err;
        logic        own;
        logic        stable;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obs_t;

    mem_arbiter_if #(.AW(32), .DW(32)) bus();

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Drive one port's request fields.
    task automatic drive_req(input bit dma, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        if (dma) begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    // Plays the memory and records what happened until the done pulse.
    // Called in an IDLE cycle with the request already driven; returns in
    // the following IDLE cycle. lat = ACCESS cycle that sees mem_ready (0 = never).
    task automatic run_txn(input int lat, input logic [31:0] rd_val, input bit drop,
                           input bit chg, input logic [31:0] chg_addr, output obs_t o);
        o = '{done_at: -1, en_cnt: 0, first_en: 0, c_done: 0, d_done: 0, c_rd: 0,
              d_rd: 0, err: 0, own: 0, stable: 0, we: 0, addr: 0, wdata: 0};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) o.first_en = bus.mem_en;
            if (bus.cpu_done || bus.dma_done) begin
                o.done_at = cyc;
                o.c_done  = bus.cpu_done;
                o.d_done  = bus.dma_done;
                o.c_rd    = bus.cpu_rdata;
                o.d_rd    = bus.dma_rdata;
                o.err     = bus.bus_err;
                o.own     = bus.owner;
                break;
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            if (bus.mem_en) begin
                o.en_cnt++;
                if (o.en_cnt == 1) begin
                    o.addr = bus.mem_addr; o.we = bus.mem_we; o.wdata = bus.mem_wdata;
                    o.stable = 1'b1;
                end else if (bus.mem_addr !== o.addr || bus.mem_we !== o.we ||
                             bus.mem_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                if (lat > 0 && o.en_cnt == lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd_val;
                end
                if (chg && o.en_cnt == 1) bus.cpu_addr = chg_addr;
            end
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        if (drop) begin
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if ({bus.cpu_done, bus.dma_done, bus.bus_err} !== 3'b000) begin n_fail++; $display("FAIL reset_done_err: got %b want 000", {bus.cpu_done, bus.dma_done, bus.bus_err}); end
        n_checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.cpu_rdata !== 32'h0 || bus.dma_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.cpu_rdata, bus.dma_rdata); end
        n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b want 1", bus.owner); end
        reset_n = 1'b1;
        last_owner = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        obs_t o;
        drive_req(1'b0, 1'b0, 32'h100, 32'h0);
        run_txn(2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, o);
        last_owner = 1'b0;
        n_checks++; if (o.done_at !== 3) begin n_fail++; $display("FAIL cpu_read_latency: got %0d want 3", o.done_at); end
        n_checks++; if ({o.c_done, o.d_done} !== 2'b10) begin n_fail++; $display("FAIL cpu_read_done: got %b want 10", {o.c_done, o.d_done}); end
        n_checks++; if (o.c_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_read_data: got %h want deadbeef", o.c_rd); end
        n_checks++; if (o.own !== 1'b0 || o.err !== 1'b0) begin n_fail++; $display("FAIL cpu_read_owner_err: got %b/%b want 0/0", o.own, o.err); end
        n_checks++; if (o.en_cnt !== 2) begin n_fail++; $display("FAIL cpu_read_en_cycles: got %0d want 2", o.en_cnt); end
        n_checks++; if (o.addr !== 32'h100 || o.we !== 1'b0) begin n_fail++; $display("FAIL cpu_read_mem_bus: got %h/%b want 100/0", o.addr, o.we); end
    endtask

    task automatic test_dma_write();
        obs_t o;
        drive_req(1'b1, 1'b1, 32'h40, 32'h1234_5678);
        run_txn(1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, o);
        last_owner = 1'b1;
        n_checks++; if (o.done_at !== 2) begin n_fail++; $display("FAIL dma_write_latency: got %0d want 2", o.done_at); end
        n_checks++; if ({o.c_done, o.d_done} !== 2'b01) begin n_fail++; $display("FAIL dma_write_done: got %b want 01", {o.c_done, o.d_done}); end
        n_checks++; if (o.we !== 1'b1 || o.addr !== 32'h40 || o.wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dma_write_mem_bus: got %b/%h/%h want 1/40/12345678", o.we, o.addr, o.wdata); end
        n_checks++; if (o.en_cnt !== 1) begin n_fail++; $display("FAIL dma_write_en_cycles: got %0d want 1", o.en_cnt); end
        n_checks++; if (o.d_rd !== 32'h0 || o.own !== 1'b1) begin n_fail++; $display("FAIL dma_write_rdata_owner: got %h/%b want 0/1", o.d_rd, o.own); end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_req(1'b0, 1'b0, 32'h200, 32'h0);
        run_txn(0, 32'h0, 1'b1, 1'b0, 32'h0, o);
        last_owner = 1'b0;
        n_checks++; if (o.en_cnt !== TIMEOUT) begin n_fail++; $display("FAIL timeout_en_cycles: got %0d want %0d", o.en_cnt, TIMEOUT); end
        n_checks++; if (o.done_at !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", o.done_at, TIMEOUT + 1); end
        n_checks++; if (o.c_done !== 1'b1 || o.err !== 1'b1 || o.c_rd !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: got done=%b err=%b rd=%h want 1/1/0", o.c_done, o.err, o.c_rd); end
        n_checks++; if (bus.mem_en !== 1'b0 || bus.cpu_done !== 1'b0 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got en=%b done=%b err=%b want 0/0/0", bus.mem_en, bus.cpu_done, bus.bus_err); end
    endtask

    task automatic test_addr_hold();
        obs_t o;
        drive_req(1'b0, 1'b0, 32'h10, 32'h0);
        run_txn(3, 32'h0A0A_0A0A, 1'b1, 1'b1, 32'h20, o);
        last_owner = 1'b0;
        n_checks++; if (o.addr !== 32'h10 || o.stable !== 1'b1) begin n_fail++; $display("FAIL addr_hold: got %h stable=%b want 10 stable=1", o.addr, o.stable); end
        n_checks++; if (o.c_rd !== 32'h0A0A_0A0A || o.done_at !== 4) begin n_fail++; $display("FAIL addr_hold_resp: got %h at %0d want 0a0a0a0a at 4", o.c_rd, o.done_at); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic exp_own;
        int   dma_dones = 0;
        drive_req(1'b0, 1'b0, 32'h300, 32'h0);
        drive_req(1'b1, 1'b0, 32'h400, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            exp_own = ~last_owner;
`else
            exp_own = OWN_CPU;
`endif
            run_txn(1, 32'h5000_0000 + i, (i == 3), 1'b0, 32'h0, o);
            last_owner = exp_own;
            if (o.d_done) dma_dones++;
            n_checks++; if (o.own !== exp_own) begin n_fail++; $display("FAIL b2b_owner[%0d]: got %b want %b", i, o.own, exp_own); end
            n_checks++; if (o.first_en !== 1'b1 || o.done_at !== 2) begin n_fail++; $display("FAIL b2b_timing[%0d]: got first_en=%b done_at=%0d want 1/2", i, o.first_en, o.done_at); end
            n_checks++; if ((exp_own ? o.d_rd : o.c_rd) !== 32'h5000_0000 + i || (exp_own ? o.c_rd : o.d_rd) !== 32'h0) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got cpu=%h dma=%h", i, o.c_rd, o.d_rd); end
        end
`ifdef MEMARB_ROUND_ROBIN_EN
        n_checks++; if (dma_dones !== 2) begin n_fail++; $display("FAIL b2b_dma_count: got %0d want 2", dma_dones); end
`else
        n_checks++; if (dma_dones !== 0) begin n_fail++; $display("FAIL b2b_dma_count: got %0d want 0", dma_dones); end
`endif
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        logic saw_done = 1'b0;
        drive_req(1'b0, 1'b0, 32'h500, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_en: got %b want 1", bus.mem_en); end
        reset_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        n_checks++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en_drop: got %b want 0", bus.mem_en); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_done || bus.dma_done) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        last_owner = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_done || bus.dma_done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b want 0", saw_done); end
        drive_req(1'b0, 1'b0, 32'h600, 32'h0);
        run_txn(2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, o);
        last_owner = 1'b0;
        n_checks++; if (o.done_at !== 3 || o.c_rd !== 32'hCAFE_F00D || o.own !== 1'b0) begin n_fail++; $display("FAIL rst_mid_recover: got at=%0d rd=%h own=%b want 3/cafef00d/0", o.done_at, o.c_rd, o.own); end
    endtask

    task automatic test_random();
        obs_t        o;
        int          mode, lat;
        logic        c_we, d_we, exp_own, exp_we;
        logic [31:0] c_addr, d_addr, c_wd, d_wd, rd, exp_rd, exp_addr, exp_wd;
        for (int t = 0; t < 24; t++) begin
            mode   = $urandom_range(0, 2);
            c_we   = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
            c_addr = $urandom; d_addr = $urandom; c_wd = $urandom; d_wd = $urandom; rd = $urandom;
            lat    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            if (mode != 1) drive_req(1'b0, c_we, c_addr, c_wd);
            if (mode != 0) drive_req(1'b1, d_we, d_addr, d_wd);
            if (mode == 0)      exp_own = OWN_CPU;
            else if (mode == 1) exp_own = OWN_DMA;
`ifdef MEMARB_ROUND_ROBIN_EN
            else                exp_own = ~last_owner;
`else
            else                exp_own = OWN_CPU;
`endif
            exp_we   = exp_own ? d_we : c_we;
            exp_addr = exp_own ? d_addr : c_addr;
            exp_wd   = exp_own ? d_wd : c_wd;
            exp_rd   = (lat == 0 || exp_we) ? 32'h0 : rd;
            run_txn(lat, rd, 1'b1, 1'b0, 32'h0, o);
            last_owner = exp_own;
            n_checks++; if (o.done_at !== ((lat == 0) ? TIMEOUT + 1 : lat + 1)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d lat=%0d", t, o.done_at, lat); end
            n_checks++; if (o.own !== exp_own || {o.c_done, o.d_done} !== (exp_own ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rnd_winner[%0d]: got own=%b done=%b%b want own=%b", t, o.own, o.c_done, o.d_done, exp_own); end
            n_checks++; if ((exp_own ? o.d_rd : o.c_rd) !== exp_rd || (exp_own ? o.c_rd : o.d_rd) !== 32'h0) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got cpu=%h dma=%h want %h", t, o.c_rd, o.d_rd, exp_rd); end
            n_checks++; if (o.err !== (lat == 0)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b lat=%0d", t, o.err, lat); end
            n_checks++; if (o.addr !== exp_addr || o.we !== exp_we || o.wdata !== exp_wd || o.stable !== 1'b1) begin n_fail++; $display("FAIL rnd_mem_bus[%0d]: got %h/%b/%h stable=%b want %h/%b/%h", t, o.addr, o.we, o.wdata, o.stable, exp_addr, exp_we, exp_wd); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_timeout();
        test_addr_hold();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
